// File: rtl/watch_pkg.sv
// Shared definitions for the watch blocks: key FSM state encoding and default timing constants.
package watch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

    localparam int DIV_DEF       = 50_000_000;
    localparam int DEB_CYC_DEF   = 1_000_000;
    localparam int REP_DELAY_DEF = 25_000_000;
    localparam int REP_RATE_DEF  = 10_000_000;
    localparam int CNT_W_DEF     = 26;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a counting debouncer; level changes only after
// DEB_CYC consecutive samples that disagree with the current debounced level.
module key_debounce
    import watch_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] deb_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            // Any agreeing sample restarts the stability count.
            if (sync_2 == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                level   <= ~level;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sec_pulse_src.sv
// Seconds pulse source: prescaled time base merged with a debounced, auto-repeating
// adjust key onto a single registered increment pulse.
module sec_pulse_src
    import watch_pkg::*;
#(
    parameter int DIV       = DIV_DEF,
    parameter int DEB_CYC   = DEB_CYC_DEF,
    parameter int REP_DELAY = REP_DELAY_DEF,
    parameter int REP_RATE  = REP_RATE_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    input  logic adj_key,
    output logic pulse,
    output logic adj_active
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REP_RATE - 1);

    logic [CNT_W-1:0] presc;
    logic             sec_tick;
    logic             key_db;
    logic             key_db_d;
    key_state_t       state;
    logic [CNT_W-1:0] tmr;
    logic             adj_req;
    logic             pend;

    key_debounce #(
        .DEB_CYC (DEB_CYC),
        .CNT_W   (CNT_W)
    ) u_key_debounce (
        .clock (clock),
        .reset (reset),
        .raw   (adj_key),
        .level (key_db)
    );

    // Prescaler: clear beats the adjust freeze, which beats enable.
    always_comb begin
        sec_tick = 1'b0;
        if (!clear && !adj_active && enable && (presc == DIV_LAST)) begin
            sec_tick = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= '0;
        end else if (clear || adj_active) begin
            presc <= '0;
        end else if (enable) begin
            presc <= (presc == DIV_LAST) ? '0 : presc + 1'b1;
        end
    end

    // Key FSM. adj_active trails the state by one cycle, so the prescaler can still
    // wrap in the same cycle as the first adjust request; the merge absorbs that.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tmr        <= '0;
            adj_req    <= 1'b0;
            adj_active <= 1'b0;
            key_db_d   <= 1'b0;
        end else begin
            key_db_d   <= key_db;
            adj_req    <= 1'b0;
            adj_active <= (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (key_db && !key_db_d) begin
                        state   <= DELAY;
                        adj_req <= 1'b1;
                        tmr     <= '0;
                    end
                end
                DELAY: begin
                    if (!key_db) begin
                        state <= IDLE;
                        tmr   <= '0;
                    end else if (tmr == RD_LAST) begin
                        state   <= REPEAT;
                        adj_req <= 1'b1;
                        tmr     <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!key_db) begin
                        state <= IDLE;
                        tmr   <= '0;
                    end else if (tmr == RR_LAST) begin
                        adj_req <= 1'b1;
                        tmr     <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tmr   <= '0;
                end
            endcase
        end
    end

    // Merge: a coincident tick and request become two back-to-back pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            pulse <= 1'b0;
            pend  <= 1'b0;
        end else begin
            pulse <= sec_tick | adj_req | pend;
            pend  <= sec_tick & adj_req;
        end
    end

endmodule

// File: tb/tb_sec_pulse_src.sv
// Bench for sec_pulse_src with small timing parameters: segment table for the time base,
// hand-written sequences for the key, with a queue of expected pulse cycles.
module tb_sec_pulse_src;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic clear;
    logic adj_key;
    logic pulse;
    logic adj_active;

    int n_checks  = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;
    int cyc       = 0;
    int exp_q[$];

    sec_pulse_src #(
        .DIV       (4),
        .DEB_CYC   (3),
        .REP_DELAY (8),
        .REP_RATE  (4),
        .CNT_W     (26)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .adj_key    (adj_key),
        .pulse      (pulse),
        .adj_active (adj_active)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every observed pulse is matched against the oldest expected pulse cycle.
    always @(posedge clock) begin
        int e;
        #1;
        if (pulse !== 1'b0) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", cyc, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_time", cyc, e);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #3;
    endtask

    task automatic drain(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    typedef struct {
        logic en;
        logic clr;
        logic key;
        int   len;
        int   first;
        int   n;
        logic adj;
    } seg_t;

    seg_t segs[13];

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int c0;
        int p0;
        int p6;

        segs[0]  = '{1'b1, 1'b0, 1'b0, 40, 4, 10, 1'b0}; // 10 ticks, 4 apart
        segs[1]  = '{1'b1, 1'b0, 1'b0,  2, 0,  0, 1'b0}; // phase to 2
        segs[2]  = '{1'b0, 1'b0, 1'b0, 10, 0,  0, 1'b0}; // hold
        segs[3]  = '{1'b1, 1'b0, 1'b0,  8, 2,  2, 1'b0}; // resumes at phase 2
        segs[4]  = '{1'b1, 1'b0, 1'b0,  1, 0,  0, 1'b0}; // phase to 3
        segs[5]  = '{1'b1, 1'b1, 1'b0,  1, 0,  0, 1'b0}; // clear on would-be wrap
        segs[6]  = '{1'b1, 1'b0, 1'b0,  4, 4,  1, 1'b0};
        segs[7]  = '{1'b0, 1'b0, 1'b0,  3, 0,  0, 1'b0};
        segs[8]  = '{1'b1, 1'b0, 1'b0,  1, 0,  0, 1'b0};
        segs[9]  = '{1'b0, 1'b0, 1'b0,  2, 0,  0, 1'b0};
        segs[10] = '{1'b1, 1'b0, 1'b0,  3, 3,  1, 1'b0};
        segs[11] = '{1'b0, 1'b0, 1'b1,  2, 0,  0, 1'b0}; // 2-cycle bounce
        segs[12] = '{1'b0, 1'b0, 1'b0, 10, 0,  0, 1'b0};

        reset   = 1'b1;
        enable  = 1'b0;
        clear   = 1'b0;
        adj_key = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("reset_pulse", pulse, 0);
            check("reset_adj_active", adj_active, 0);
        end
        reset = 1'b0;

        for (int s = 0; s < 13; s++) begin
            enable  = segs[s].en;
            clear   = segs[s].clr;
            adj_key = segs[s].key;
            c0 = cyc;
            p0 = pulse_cnt;
            for (int i = 0; i < segs[s].n; i++) exp_q.push_back(c0 + segs[s].first + 4 * i);
            for (int k = 1; k <= segs[s].len; k++) begin
                step();
                check("seg_adj_active", adj_active, segs[s].adj);
            end
            check("seg_pulse_count", pulse_cnt - p0, segs[s].n);
            drain("seg_missing_pulse");
        end
        enable  = 1'b0;
        clear   = 1'b0;
        adj_key = 1'b0;

        // Held key, time base stopped: first pulse, delay, repeat, release.
        c0 = cyc;
        p0 = pulse_cnt;
        adj_key = 1'b1;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(c0 + 7);
        exp_q.push_back(c0 + 15);
        exp_q.push_back(c0 + 19);
        exp_q.push_back(c0 + 23);
        exp_q.push_back(c0 + 27);
        exp_q.push_back(c0 + 31);
        exp_q.push_back(c0 + 35);
        for (int k = 1; k <= 40; k++) begin
            step();
            check("hold_adj_active", adj_active, (k >= 7 && k <= 36) ? 1 : 0);
            if (k == 30) adj_key = 1'b0;
        end
        check("hold_pulse_count", pulse_cnt - p0, 7);
        drain("hold_missing_pulse");

        // First adjust request lands on a prescaler wrap.
        enable = 1'b1;
        step();
        c0 = cyc;
        p0 = pulse_cnt;
        p6 = 0;
        adj_key = 1'b1;
        exp_q.push_back(c0 + 3);
        exp_q.push_back(c0 + 7);
        exp_q.push_back(c0 + 8);
        exp_q.push_back(c0 + 15);
        exp_q.push_back(c0 + 19);
        for (int k = 1; k <= 20; k++) begin
            step();
            check("coinc_adj_active", adj_active, (k >= 7 && k <= 10) ? 1 : 0);
            if (k == 4) adj_key = 1'b0;
            if (k == 6) p6 = pulse_cnt;
            if (k == 8) check("coinc_two_pulses", pulse_cnt - p6, 2);
        end
        check("coinc_pulse_count", pulse_cnt - p0, 5);
        drain("coinc_missing_pulse");

        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        step();
        enable = 1'b0;

        // Reset during REPEAT with a request in flight; key stays held across it.
        c0 = cyc;
        p0 = pulse_cnt;
        adj_key = 1'b1;
        exp_q.push_back(c0 + 7);
        exp_q.push_back(c0 + 15);
        exp_q.push_back(c0 + 26);
        exp_q.push_back(c0 + 34);
        for (int k = 1; k <= 40; k++) begin
            step();
            check("rst_adj_active", adj_active,
                  ((k >= 7 && k <= 18) || (k >= 26 && k <= 36)) ? 1 : 0);
            if (k == 19) check("rst_pulse_cleared", pulse, 0);
            if (k == 18) reset = 1'b1;
            if (k == 19) reset = 1'b0;
            if (k == 30) adj_key = 1'b0;
        end
        check("rst_pulse_count", pulse_cnt - p0, 4);
        drain("rst_missing_pulse");

        // Reset also restarted the prescaler phase from 2 to 0.
        enable = 1'b1;
        c0 = cyc;
        exp_q.push_back(c0 + 4);
        for (int k = 1; k <= 4; k++) step();
        drain("rst_presc_phase");
        enable = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
